// File: rtl/ckpt_seq_monitor.sv
// Checkpoint-sequence monitor: verifies programmed codes appear in order.
// Optional order-error detection enabled by defining CKPT_ORDER_ERR_EN.
module ckpt_seq_monitor #(
   parameter  int CHK_W         = 16,
   parameter  int NUM_CKPT      = 8,
   parameter  int TIMEOUT_W     = 24,
   parameter  int STABLE_CYCLES = 2,
   localparam int IDX_W         = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 cfg_we,
   input  logic [IDX_W-1:0]     cfg_addr,
   input  logic [CHK_W-1:0]     cfg_wdata,
   input  logic [IDX_W:0]       cfg_len,
   input  logic [TIMEOUT_W-1:0] cfg_timeout,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CHK_W-1:0]     checkbits,
   output logic                 busy,
   output logic                 pass,
   output logic                 fail,
   output logic [1:0]           fail_code,
   output logic [IDX_W:0]       ckpt_idx
);

   localparam int SC_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);
   localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);
   localparam logic [IDX_W:0] LEN_MAX = (IDX_W + 1)'(NUM_CKPT);
   localparam logic [IDX_W:0] IDX_ONE = (IDX_W + 1)'(1);
   localparam logic [TIMEOUT_W-1:0] TMR_ONE = TIMEOUT_W'(1);

   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_TMO   = 2'b01;
   localparam logic [1:0] FC_ABORT = 2'b10;
   localparam logic [1:0] FC_ORDER = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PASS,
      ST_FAIL
   } state_t;

   state_t                 r_state;
   logic [CHK_W-1:0]       r_chk_q;
   logic [CHK_W-1:0]       r_table [NUM_CKPT];
   logic [IDX_W:0]         r_idx;
   logic [SC_W-1:0]        r_stab;
   logic [TIMEOUT_W-1:0]   r_tmr;
   logic [IDX_W:0]         r_len;
   logic [TIMEOUT_W-1:0]   r_tmo;
   logic                   r_busy;
   logic                   r_pass;
   logic                   r_fail;
   logic [1:0]             r_code;

   logic [CHK_W-1:0]       w_cur;
   logic                   w_match;
   logic                   w_adv;
   logic                   w_last;
   logic                   w_tmo;
   logic [IDX_W:0]         w_len_c;
   logic                   w_ord_err;

   assign w_cur   = r_table[r_idx[IDX_W-1:0]];
   assign w_match = (r_chk_q == w_cur);
   assign w_adv   = w_match && (r_stab == SC_LAST);
   assign w_last  = ((r_idx + IDX_ONE) == r_len);
   assign w_tmo   = (r_tmo != '0) && (r_tmr == (r_tmo - TMR_ONE));
   assign w_len_c = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

`ifdef CKPT_ORDER_ERR_EN
   logic [SC_W-1:0]  r_ord_cnt;
   logic [CHK_W-1:0] r_chk_d;
   logic             w_ord_hit;
   logic             w_ord_same;

   // Flag a sample that matches a later table entry but not the current one
   always_comb begin
      w_ord_hit = 1'b0;
      for (int j = 0; j < NUM_CKPT; j++) begin
         if (((IDX_W + 1)'(j) > r_idx) &&
             ((IDX_W + 1)'(j) < r_len) &&
             (r_chk_q == r_table[j])) begin
            w_ord_hit = 1'b1;
         end
      end
      if (w_match) begin
         w_ord_hit = 1'b0;
      end
   end

   assign w_ord_same = (r_ord_cnt == '0) || (r_chk_q == r_chk_d);
   assign w_ord_err  = w_ord_hit && w_ord_same && (r_ord_cnt == SC_LAST);

   // Count consecutive identical out-of-order samples
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ord_cnt <= '0;
         r_chk_d   <= '0;
      end else begin
         r_chk_d <= r_chk_q;
         if (start || (r_state != ST_RUN) || w_adv) begin
            r_ord_cnt <= '0;
         end else if (w_ord_hit && w_ord_same) begin
            if (r_ord_cnt != SC_LAST) begin
               r_ord_cnt <= r_ord_cnt + SC_ONE;
            end
         end else if (w_ord_hit) begin
            r_ord_cnt <= SC_ONE;
         end else begin
            r_ord_cnt <= '0;
         end
      end
   end
`else
   assign w_ord_err = 1'b0;
`endif

   // Expected-code table, frozen while a run is in progress
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < NUM_CKPT; i++) begin
            r_table[i] <= '0;
         end
      end else if (cfg_we && (r_state != ST_RUN) &&
                   ({1'b0, cfg_addr} < LEN_MAX)) begin
         r_table[cfg_addr] <= cfg_wdata;
      end
   end

   // Run-control FSM with registered status outputs
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_chk_q <= '0;
         r_idx   <= '0;
         r_stab  <= '0;
         r_tmr   <= '0;
         r_len   <= '0;
         r_tmo   <= '0;
         r_busy  <= 1'b0;
         r_pass  <= 1'b0;
         r_fail  <= 1'b0;
         r_code  <= FC_NONE;
      end else begin
         r_chk_q <= checkbits;
         if (start) begin
            r_idx  <= '0;
            r_stab <= '0;
            r_tmr  <= '0;
            r_fail <= 1'b0;
            r_code <= FC_NONE;
            r_len  <= w_len_c;
            r_tmo  <= cfg_timeout;
            if (w_len_c == '0) begin
               r_state <= ST_PASS;
               r_busy  <= 1'b0;
               r_pass  <= 1'b1;
            end else begin
               r_state <= ST_RUN;
               r_busy  <= 1'b1;
               r_pass  <= 1'b0;
            end
         end else if (r_state == ST_RUN) begin
            if (abort) begin
               r_state <= ST_FAIL;
               r_busy  <= 1'b0;
               r_fail  <= 1'b1;
               r_code  <= FC_ABORT;
            end else if (w_adv) begin
               r_idx  <= r_idx + IDX_ONE;
               r_stab <= '0;
               r_tmr  <= '0;
               if (w_last) begin
                  r_state <= ST_PASS;
                  r_busy  <= 1'b0;
                  r_pass  <= 1'b1;
               end
            end else if (w_ord_err) begin
               r_state <= ST_FAIL;
               r_busy  <= 1'b0;
               r_fail  <= 1'b1;
               r_code  <= FC_ORDER;
            end else begin
               r_tmr <= r_tmr + TMR_ONE;
               if (!w_match) begin
                  r_stab <= '0;
               end else if (r_stab != SC_LAST) begin
                  r_stab <= r_stab + SC_ONE;
               end
               if (w_tmo) begin
                  r_state <= ST_FAIL;
                  r_busy  <= 1'b0;
                  r_fail  <= 1'b1;
                  r_code  <= FC_TMO;
               end
            end
         end
      end
   end

   assign busy      = r_busy;
   assign pass      = r_pass;
   assign fail      = r_fail;
   assign fail_code = r_code;
   assign ckpt_idx  = r_idx;

endmodule

// File: tb/tb_ckpt_seq_monitor.sv
// Directed self-checking bench for ckpt_seq_monitor.
// Expected fail code for the order test depends on CKPT_ORDER_ERR_EN.
module tb_ckpt_seq_monitor;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic [3:0]  cfg_len;
   logic [23:0] cfg_timeout;
   logic        start;
   logic        abort;
   logic [15:0] checkbits;
   logic        busy;
   logic        pass;
   logic        fail;
   logic [1:0]  fail_code;
   logic [3:0]  ckpt_idx;

   int n_chk;
   int n_fail;

   ckpt_seq_monitor dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_wdata   (cfg_wdata),
      .cfg_len     (cfg_len),
      .cfg_timeout (cfg_timeout),
      .start       (start),
      .abort       (abort),
      .checkbits   (checkbits),
      .busy        (busy),
      .pass        (pass),
      .fail        (fail),
      .fail_code   (fail_code),
      .ckpt_idx    (ckpt_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      step();
      cfg_we    = 1'b0;
   endtask

   task automatic run(input logic [3:0] l, input logic [23:0] t);
      cfg_len     = l;
      cfg_timeout = t;
      start       = 1'b1;
      step();
      start       = 1'b0;
   endtask

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      rst         = 1'b1;
      cfg_we      = 1'b0;
      cfg_addr    = '0;
      cfg_wdata   = '0;
      cfg_len     = '0;
      cfg_timeout = '0;
      start       = 1'b0;
      abort       = 1'b0;
      checkbits   = '0;
      step(2);
      rst = 1'b0;
      step();

      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_pass", pass, 0);
      chk_eq("rst_fail", fail, 0);
      chk_eq("rst_code", fail_code, 0);
      chk_eq("rst_idx", ckpt_idx, 0);

      // basic two-code pass
      wr(0, 16'hAB60);
      wr(1, 16'hAB61);
      run(2, 1000);
      chk_eq("t1_busy", busy, 1);
      checkbits = 16'hAB60;
      step(2);
      chk_eq("t1_idx0", ckpt_idx, 0);
      step();
      chk_eq("t1_idx1", ckpt_idx, 1);
      step(2);
      checkbits = 16'hAB61;
      step(2);
      chk_eq("t1_nopass", pass, 0);
      chk_eq("t1_idx1b", ckpt_idx, 1);
      step();
      chk_eq("t1_pass", pass, 1);
      chk_eq("t1_idx2", ckpt_idx, 2);
      chk_eq("t1_busy0", busy, 0);
      chk_eq("t1_fail", fail, 0);

      // glitch rejected, then timeout on edge 20
      checkbits = 16'h0000;
      run(2, 20);
      checkbits = 16'hAB60;
      step();
      checkbits = 16'h0000;
      step(17);
      chk_eq("t2_idx", ckpt_idx, 0);
      chk_eq("t2_fail18", fail, 0);
      step();
      chk_eq("t2_fail19", fail, 0);
      chk_eq("t2_busy19", busy, 1);
      step();
      chk_eq("t2_fail20", fail, 1);
      chk_eq("t2_code", fail_code, 1);
      chk_eq("t2_busy", busy, 0);

      // advance on the last timer cycle beats timeout
      run(1, 3);
      checkbits = 16'hAB60;
      step(3);
      chk_eq("t3_pass", pass, 1);
      chk_eq("t3_fail", fail, 0);
      chk_eq("t3_code", fail_code, 0);

      // timeout disabled: run stays busy
      checkbits = 16'h0000;
      run(2, 0);
      step(10000);
      chk_eq("t3_busy", busy, 1);
      chk_eq("t3_nofail", fail, 0);

      // abort at idx 1, then zero-length run
      run(2, 1000);
      checkbits = 16'hAB60;
      step(3);
      chk_eq("t4_idx", ckpt_idx, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk_eq("t4_fail", fail, 1);
      chk_eq("t4_code", fail_code, 2);
      chk_eq("t4_idx1", ckpt_idx, 1);
      chk_eq("t4_busy", busy, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk_eq("t4_hold", fail_code, 2);
      run(0, 0);
      chk_eq("t4_len0_pass", pass, 1);
      chk_eq("t4_len0_fail", fail, 0);
      chk_eq("t4_len0_code", fail_code, 0);
      chk_eq("t4_len0_busy", busy, 0);

      // table write ignored during RUN
      checkbits = 16'h0000;
      run(1, 0);
      wr(0, 16'h1234);
      abort = 1'b1;
      step();
      abort = 1'b0;
      run(1, 1000);
      checkbits = 16'hAB60;
      step(3);
      chk_eq("t5_keep", pass, 1);

      // length clamped to 8
      for (int i = 0; i < 8; i++) begin
         wr(3'(i), 16'h0100 + 16'(i));
      end
      checkbits = 16'h0000;
      run(15, 0);
      for (int i = 0; i < 8; i++) begin
         checkbits = 16'h0100 + 16'(i);
         step(3);
         if (i == 6) begin
            chk_eq("t5_idx7", ckpt_idx, 7);
            chk_eq("t5_nopass", pass, 0);
         end
      end
      chk_eq("t5_clamp_pass", pass, 1);
      chk_eq("t5_clamp_idx", ckpt_idx, 8);

      // later code seen at idx 0
      wr(0, 16'h0001);
      wr(1, 16'h0002);
      wr(2, 16'h0003);
      checkbits = 16'h0000;
      run(3, 20);
      checkbits = 16'h0003;
      step(25);
      chk_eq("t6_fail", fail, 1);
`ifdef CKPT_ORDER_ERR_EN
      chk_eq("t6_code", fail_code, 3);
`else
      chk_eq("t6_code", fail_code, 1);
`endif
      chk_eq("t6_idx", ckpt_idx, 0);

      // reset mid-run clears outputs and table
      checkbits = 16'h0000;
      run(3, 0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_eq("t7_busy", busy, 0);
      chk_eq("t7_fail", fail, 0);
      chk_eq("t7_idx", ckpt_idx, 0);
      run(1, 5);
      step(2);
      chk_eq("t7_tbl_clr", pass, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ckpt_seq_monitor.md
Name: ckpt_seq_monitor

Overview:
- Synthesizable checkpoint-sequence monitor for the user project area.
- Watches a CHK_W-bit checkbit bus, normally driven by firmware through mprj_io GPIOs.
- Confirms that up to NUM_CKPT programmed codes appear in order, each within a per-checkpoint cycle window.
- Reports sticky pass/fail with a cause code. On-chip successor to bench-side two-code wait-and-timeout monitoring: parametrised width, depth, timeout and glitch filtering.

Parameters:
- CHK_W, 16, width of checkbit bus and of each expected code.
- NUM_CKPT, 8, depth of expected-code table. IDX_W = max(1, clog2(NUM_CKPT)).
- TIMEOUT_W, 24, width of per-checkpoint timeout counter.
- STABLE_CYCLES, 2, consecutive matching samples required to accept a code (>=1).

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous, active-high reset
- cfg_we  in  1  write expected-code table entry
- cfg_addr  in  IDX_W  table write index
- cfg_wdata  in  CHK_W  expected code
- cfg_len  in  IDX_W+1  number of checkpoints to check; sampled at start
- cfg_timeout  in  TIMEOUT_W  per-checkpoint window in cycles, 0 = disabled; sampled at start
- start  in  1  begin or restart a check run
- abort  in  1  terminate run as failure
- checkbits  in  CHK_W  monitored bus (asynchronous to firmware; registered on entry)
- busy  out  1  run in progress
- pass  out  1  sticky: all checkpoints seen
- fail  out  1  sticky: run failed
- fail_code  out  2  00 none, 01 timeout, 10 abort, 11 order error
- ckpt_idx  out  IDX_W+1  number of checkpoints accepted so far

Behaviour:
- Reset: state IDLE; busy=pass=fail=0, fail_code=00, ckpt_idx=0; all table entries=0; internal counters=0; input register=0.
- Input path: checkbits registered once into chk_q. All comparisons use chk_q.
- Table writes:
  - cfg_we with cfg_addr<NUM_CKPT writes the entry in any state except RUN.
  - Writes in RUN, or with out-of-range cfg_addr, are ignored.
- States: IDLE, RUN, PASS, FAIL.
- start (any state):
  - Next state RUN; idx=0, stab_cnt=0, tmr=0, pass=fail=0, fail_code=00.
  - len_q=min(cfg_len, NUM_CKPT); tmo_q=cfg_timeout.
  - If len_q==0, next state is PASS directly.
  - start has priority over abort and all RUN events.
- RUN, each cycle:
  - stab_cnt increments while chk_q==table[idx], saturating at STABLE_CYCLES; clears on mismatch.
  - Advance occurs in the cycle where stab_cnt would reach STABLE_CYCLES: idx++, stab_cnt=0, tmr=0.
  - After an advance, a repeated identical next entry needs a fresh STABLE_CYCLES of matching samples.
  - Advance to idx==len_q: next state PASS, pass=1.
  - Timeout: tmr increments each non-advance cycle. If tmo_q!=0 and tmr==tmo_q-1 with no advance this cycle: FAIL, fail_code=01.
  - Advance beats timeout in the same cycle.
  - abort (without start): FAIL, fail_code=10. abort beats advance and timeout.
- Latency: a final code first driven on checkbits in cycle t gives pass=1 visible at cycle t+STABLE_CYCLES+1.
- Outputs: busy=1 only in RUN. ckpt_idx=idx. pass/fail/fail_code hold in PASS/FAIL until start or reset. abort in IDLE/PASS/FAIL has no effect.
- Reset mid-run returns to IDLE, clears the table and all outputs.

Optional Feature:
- Macro CKPT_ORDER_ERR_EN.
- Defined: in RUN, chk_q stable for STABLE_CYCLES on a value equal to table[j] for some idx<j<len_q, and not equal to table[idx], causes FAIL with fail_code=11. Priority order is start > abort > advance > order error > timeout.
- Undefined: such codes are treated as plain mismatches; fail_code 11 is never produced and no extra comparators are built.

Test Plan:
- Table {AB60, AB61}, len=2, timeout=1000, STABLE=2. Drive AB60 for 5 cycles, then AB61. Expect ckpt_idx 0->1->2; pass=1 exactly 3 cycles after AB61 is first driven; busy=0; fail=0.
- Glitch filter: AB60 for a single cycle, then 0000. Expect ckpt_idx stays 0. Then timeout=20 with no matching code: expect fail=1, fail_code=01 on cycle 20 after start.
- Boundary: last match accepted in the same cycle tmr==tmo_q-1. Expect advance wins and no timeout. timeout=0 with idle bus for 10000 cycles: expect busy stays 1.
- abort in RUN at idx=1: expect fail_code=10, ckpt_idx=1. Then start with len=0: expect PASS on the next cycle.
- cfg_we to entry 0 during RUN: expect entry unchanged, verified by a rerun. cfg_len=15 with NUM_CKPT=8: expect clamp to 8, pass after 8 codes.
- With CKPT_ORDER_ERR_EN defined: table {1,2,3}, drive 3 at idx 0. Expect fail_code=11. With the macro undefined, the same stimulus times out with fail_code=01.
